// File: rtl/memory_request_sequencer_pkg.sv
// Shared types and default widths for the memory request sequencer.
// The request struct here uses the default widths; the top re-declares it at its own parameters.
package mem_seq_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    TURN
  } seq_state_t;

  // The downstream state machine needs a sleep cycle whenever direction flips.
  function automatic logic dir_change(input logic prev_write, input logic next_write);
    return prev_write != next_write;
  endfunction

endpackage

// File: rtl/memory_request_sequencer_sync_fifo.sv
// Synchronous FIFO with registered count; storage is unreset, pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/memory_request_sequencer.sv
// Queues read/write requests and issues them as a one-hot-or-zero r/w pair to the array
// state machine, with an idle turnaround cycle on every direction change.
module memory_request_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              r,
  output logic              w,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  seq_state_t             state;
  seq_state_t             next_state;
  logic                   last_dir;
  logic                   issue;
  logic                   fifo_pop;
  logic                   fifo_push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [REQ_W-1:0]       fifo_head;
  req_t                   head;
  logic [ADDR_W-1:0]      op_addr;
  logic [DATA_W-1:0]      op_wdata;

  assign req_ready = !fifo_full && !rst;
  assign fifo_push = req_valid && req_ready;
  assign head      = req_t'(fifo_head);
  assign busy      = (fifo_count != '0) | r | w | mem_valid;

  sync_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data({req_write, req_addr, req_wdata}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // IDLE and TURN both already present r=w=0 this cycle, so either direction may issue next.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          issue      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (fifo_empty) begin
          next_state = IDLE;
        end else if (dir_change(last_dir, head.write)) begin
          next_state = TURN;
        end else begin
          fifo_pop = 1'b1;
          issue    = 1'b1;
        end
      end
      TURN: begin
        if (fifo_empty) begin
          next_state = IDLE;
        end else begin
          fifo_pop   = 1'b1;
          issue      = 1'b1;
          next_state = ISSUE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Issue stage: r/w plus the popped request's fields, one cycle ahead of the mem_* strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_dir <= 1'b0;
      r        <= 1'b0;
      w        <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else begin
      state <= next_state;
      r     <= issue && !head.write;
      w     <= issue && head.write;
      if (issue) begin
        last_dir <= head.write;
        op_addr  <= head.addr;
        op_wdata <= head.wdata;
      end
    end
  end

  // mem_* lines up with the state machine's registered active state; fields hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_valid <= r | w;
      if (r | w) begin
        mem_write <= w;
        mem_addr  <= op_addr;
        mem_wdata <= op_wdata;
      end
    end
  end

endmodule

// File: tb/tb_memory_request_sequencer.sv
// Directed bench for memory_request_sequencer: scoreboard on mem_* plus cycle traces of r/w/mem_valid/busy.
module tb_memory_request_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready;
  logic       r;
  logic       w;
  logic       mem_valid;
  logic       mem_write;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;

  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_item;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [1:0] rw_hist   [512];
  logic       mv_hist   [512];
  logic       busy_hist [512];
  logic [1:0] prev_rw = 2'b00;

  logic [1:0] t1_rw   [7] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
  logic       t1_mv   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       t1_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] t2_rw   [6] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
  logic       t2_mv   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  memory_request_sequencer #(
    .ADDR_W(4),
    .DATA_W(8),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .r        (r),
    .w        (w),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; holds the request until accepted and returns at the negedge after the push.
  task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [7:0] d, output int stalls);
    stalls    = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: actual=ready low for %0d cycles required=accept", stalls);
    end else begin
      exp_q.push_back('{write: wr, addr: a, wdata: d});
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Monitor: samples just after each rising edge, records traces and drains the scoreboard.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cyc < 512) begin
      rw_hist[cyc]   = {r, w};
      mv_hist[cyc]   = mem_valid;
      busy_hist[cyc] = busy;
    end
    if (rst) begin
      exp_q.delete();
      prev_rw = 2'b00;
    end else begin
      if (r | w) begin
        checkOutput("rw_onehot", {31'b0, r & w}, 32'd0);
        if (prev_rw != 2'b00)
          checkOutput("turnaround", {31'b0, prev_rw != {r, w}}, 32'd0);
      end
      prev_rw = {r, w};
      if (mem_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_mem_valid: actual=addr 0x%0h required=no op", mem_addr);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput("mem_write", {31'b0, mem_write}, {31'b0, exp_item.write});
          checkOutput("mem_addr", {28'b0, mem_addr}, {28'b0, exp_item.addr});
          if (exp_item.write)
            checkOutput("mem_wdata", {24'b0, mem_wdata}, {24'b0, exp_item.wdata});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=no finish required=finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int st;
    int active;
    int first_op;
    int last_op;
    int stall_tab [8];

    repeat (3) @(negedge clk);
    checkOutput("rst_r", {31'b0, r}, 32'd0);
    checkOutput("rst_w", {31'b0, w}, 32'd0);
    checkOutput("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    checkOutput("rst_mem_write", {31'b0, mem_write}, 32'd0);
    checkOutput("rst_mem_addr", {28'b0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);

    $display("[TB] test 1: three reads back to back");
    base = cyc;
    applyStimulus(1'b0, 4'd1, 8'h00, st);
    applyStimulus(1'b0, 4'd2, 8'h00, st);
    applyStimulus(1'b0, 4'd3, 8'h00, st);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("t1_rw[%0d]", i), {30'b0, rw_hist[base + 1 + i]}, {30'b0, t1_rw[i]});
      checkOutput($sformatf("t1_mem_valid[%0d]", i), {31'b0, mv_hist[base + 1 + i]}, {31'b0, t1_mv[i]});
      checkOutput($sformatf("t1_busy[%0d]", i), {31'b0, busy_hist[base + 1 + i]}, {31'b0, t1_busy[i]});
    end

    $display("[TB] test 2: read then write with turnaround");
    base = cyc;
    applyStimulus(1'b0, 4'd5, 8'h00, st);
    applyStimulus(1'b1, 4'd6, 8'hA5, st);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t2_rw[%0d]", i), {30'b0, rw_hist[base + 1 + i]}, {30'b0, t2_rw[i]});
      checkOutput($sformatf("t2_mem_valid[%0d]", i), {31'b0, mv_hist[base + 1 + i]}, {31'b0, t2_mv[i]});
    end

    $display("[TB] test 3: alternating burst fills the queue");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[0], 4'(8 + i), 8'(8'h10 + i), st);
      stall_tab[i] = st;
    end
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t3_stall[%0d]", i), stall_tab[i], (i == 7) ? 32'd1 : 32'd0);
    repeat (30) @(negedge clk);

    $display("[TB] test 4: six alternating ops");
    base = cyc;
    for (int i = 0; i < 6; i++)
      applyStimulus(!i[0], 4'(i), 8'(8'hC0 + i), st);
    repeat (16) @(negedge clk);
    active   = 0;
    first_op = 0;
    last_op  = 0;
    for (int i = base + 1; i <= base + 20; i++) begin
      if (rw_hist[i] != 2'b00) begin
        active++;
        if (first_op == 0) first_op = i;
        last_op = i;
      end
    end
    checkOutput("t4_op_count", active, 32'd6);
    checkOutput("t4_first_latency", first_op - base, 32'd2);
    checkOutput("t4_issue_span", last_op - first_op + 1, 32'd11);

    $display("[TB] test 5: reset with queued and in-flight ops");
    base = cyc;
    for (int i = 0; i < 6; i++)
      applyStimulus(!i[0], 4'(i), 8'(8'h50 + i), st);
    checkOutput("t5_w_before_reset", {31'b0, w}, 32'd1);
    checkOutput("t5_busy_before_reset", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_r", {31'b0, r}, 32'd0);
    checkOutput("t5_w", {31'b0, w}, 32'd0);
    checkOutput("t5_mem_valid", {31'b0, mem_valid}, 32'd0);
    checkOutput("t5_busy", {31'b0, busy}, 32'd0);
    checkOutput("t5_ready_in_reset", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    active = 0;
    for (int i = base + 8; i <= base + 19; i++)
      if (rw_hist[i] != 2'b00 || mv_hist[i] || busy_hist[i]) active++;
    checkOutput("t5_activity_after_reset", active, 32'd0);

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
